// File: rtl/fp_norm_round_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the binary32 add/sub back end.
//   fp_32b_t      : packed binary32 {sign, exp, frac}
//   fp_raw_sum_t  : raw significand from the align-and-add front end
//   RNE..RMM      : rounding-mode encodings (codes 101..111 behave as RNE)
//   FP_QNAN, FP_MAXFIN_MAG : canonical quiet NaN and largest finite magnitude
// Helpers decide the rounding increment and the overflow result style.
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int FP_MANT_W = 28;
    localparam int FP_LZC_W  = 5;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp_32b_t;

    typedef struct packed {
        logic        carry;
        logic        hidden;
        logic [22:0] frac;
        logic        g;
        logic        r;
        logic        s;
    } fp_raw_sum_t;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    localparam logic [31:0] FP_QNAN       = 32'h7FC00000;
    localparam logic [30:0] FP_MAXFIN_MAG = 31'h7F7FFFFF;

    // Whether the kept significand is bumped by one ulp. Unknown codes
    // fall into the default arm and round to nearest-even.
    function automatic logic round_increment(input logic [2:0] rm,
                                             input logic       sign,
                                             input logic       lsb,
                                             input logic       g,
                                             input logic       s);
        logic inc;
        case (rm)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (g | s);
            RUP:     inc = ~sign & (g | s);
            RMM:     inc = g;
            default: inc = g & (s | lsb);
        endcase
        return inc;
    endfunction

    // Modes that round toward zero for this sign saturate to the largest
    // finite value instead of producing infinity on overflow.
    function automatic logic overflow_to_maxfin(input logic [2:0] rm,
                                                input logic       sign);
        return (rm == RTZ) | ((rm == RDN) & ~sign) | ((rm == RUP) & sign);
    endfunction

endpackage

// File: rtl/fp_norm_round_pipeline_if.sv
// -----------------------------------------------------------------------------
// fp_norm_round_pipeline_if
// Bundles the input beat (valid/ready + payload + rounding mode) and the
// output beat (valid/ready + packed result + IEEE status flags).
//   modport slave  : the normalize/round pipeline
//   modport master : whatever feeds it and consumes its results
// -----------------------------------------------------------------------------
interface fp_norm_round_pipeline_if;
    import fp_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [7:0]           in_exp;
    logic [FP_MANT_W-1:0] in_mant;
    logic                 in_special;
    logic [31:0]          in_special_result;
    logic                 in_invalid;
    logic                 in_flushed;
    logic [2:0]           rounding_mode;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out;
    logic                 overflow;
    logic                 underflow;
    logic                 inexact;
    logic                 invalid_operation;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_special,
               in_special_result, in_invalid, in_flushed, rounding_mode,
               out_ready,
        output in_ready, out_valid, out, overflow, underflow, inexact,
               invalid_operation
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_special,
               in_special_result, in_invalid, in_flushed, rounding_mode,
               out_ready,
        input  in_ready, out_valid, out, overflow, underflow, inexact,
               invalid_operation
    );
endinterface

// File: rtl/fp_norm_round_pipeline_lzc28.sv
// -----------------------------------------------------------------------------
// fp_lzc28
// Combinational leading-zero counter over the 27-bit {hidden, frac, g, r, s}
// field of the raw significand.
//   i_bits  [26:0]      : value to scan, bit 26 is the MSB
//   o_count [LZC_W-1:0] : number of leading zeros (27 when i_bits == 0)
// -----------------------------------------------------------------------------
module fp_lzc28 #(
    parameter int LZC_W = 5
) (
    input  logic [26:0]      i_bits,
    output logic [LZC_W-1:0] o_count
);
    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        o_count = LZC_W'(27);
        for (int i = 0; i < 27; i++) begin
            if (i_bits[i]) begin
                o_count = LZC_W'(26 - i);
            end
        end
    end
endmodule

// File: rtl/fp_norm_round_pipeline.sv
// -----------------------------------------------------------------------------
// fp_norm_round_pipeline
// Back end of the binary32 add/sub datapath: normalizes the raw significand
// (stage 1), rounds, packs and raises status flags (stage 2). Global-stall
// valid/ready pipeline, 2-cycle latency, one beat per cycle. Denormal
// results flush to signed zero.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : in_* beat + rounding_mode, out beat + overflow/underflow/
//                  inexact/invalid_operation
// Optional (FP_NR_STICKY_FLAGS_EN defined):
//   flags_clear  : synchronous clear of the sticky flags (wins over update)
//   flags_sticky : {invalid, overflow, underflow, inexact} OR-accumulated
//                  over every emitted beat
// -----------------------------------------------------------------------------
module fp_norm_round_pipeline
    import fp_pkg::*;
#(
    parameter int MANT_W = FP_MANT_W,
    parameter int LZC_W  = FP_LZC_W
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef FP_NR_STICKY_FLAGS_EN
    input  logic       flags_clear,
    output logic [3:0] flags_sticky,
`endif
    fp_norm_round_pipeline_if.slave bus
);

    // ---------------- pipeline control ----------------
    logic w_advance;
    logic r_out_valid;

    assign w_advance    = bus.out_ready | ~r_out_valid;
    assign bus.in_ready = w_advance;

    // ---------------- stage 1: normalize ----------------
    fp_raw_sum_t              w_raw;
    logic [LZC_W-1:0]         w_lzc;
    logic [MANT_W-2:0]        w_norm_mant;
    logic signed [9:0]        w_norm_exp;
    logic                     w_zero;

    assign w_raw = bus.in_mant;

    fp_lzc28 #(.LZC_W(LZC_W)) u_lzc (
        .i_bits  (bus.in_mant[MANT_W-2:0]),
        .o_count (w_lzc)
    );

    always_comb begin
        w_zero      = (w_raw == '0);
        w_norm_mant = bus.in_mant[MANT_W-2:0] << w_lzc;
        w_norm_exp  = $signed(10'(bus.in_exp)) - $signed(10'(w_lzc));
        if (w_raw.carry) begin
            // Carry out: shift right one, folding the two dropped-off
            // positions into the new sticky bit.
            w_norm_mant = {bus.in_mant[MANT_W-1:2], bus.in_mant[1] | bus.in_mant[0]};
            w_norm_exp  = $signed(10'(bus.in_exp)) + 10'sd1;
        end
    end

    logic                     r_s1_valid;
    logic                     r_s1_sign;
    logic                     r_s1_special;
    logic [31:0]              r_s1_special_result;
    logic                     r_s1_invalid;
    logic                     r_s1_flushed;
    logic [2:0]               r_s1_rm;
    logic                     r_s1_zero;
    logic signed [9:0]        r_s1_exp;
    logic [MANT_W-2:0]        r_s1_mant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid          <= 1'b0;
            r_s1_sign           <= 1'b0;
            r_s1_special        <= 1'b0;
            r_s1_special_result <= '0;
            r_s1_invalid        <= 1'b0;
            r_s1_flushed        <= 1'b0;
            r_s1_rm             <= '0;
            r_s1_zero           <= 1'b0;
            r_s1_exp            <= '0;
            r_s1_mant           <= '0;
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign           <= bus.in_sign;
                r_s1_special        <= bus.in_special;
                r_s1_special_result <= bus.in_special_result;
                r_s1_invalid        <= bus.in_invalid;
                r_s1_flushed        <= bus.in_flushed;
                r_s1_rm             <= bus.rounding_mode;
                r_s1_zero           <= w_zero;
                r_s1_exp            <= w_norm_exp;
                r_s1_mant           <= w_norm_mant;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic              w_g;
    logic              w_s;
    logic              w_inc;
    logic [23:0]       w_frac_sum;
    logic              w_carry;
    logic signed [9:0] w_exp_r;
    fp_32b_t           w_result;
    logic              w_ovf;
    logic              w_unf;
    logic              w_inx;
    logic              w_inv;

    always_comb begin
        w_g   = r_s1_mant[2];
        w_s   = r_s1_mant[1] | r_s1_mant[0];
        w_inc = round_increment(r_s1_rm, r_s1_sign, r_s1_mant[3], w_g, w_s);
        // Increment the 23-bit fraction; a carry into bit 23 with the
        // hidden bit set means the significand wrapped to 2.0.
        w_frac_sum = {1'b0, r_s1_mant[25:3]} + {23'b0, w_inc};
        w_carry    = r_s1_mant[26] & w_frac_sum[23];
        w_exp_r    = r_s1_exp + $signed({9'b0, w_carry});

        w_result = '0;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_inx    = 1'b0;
        w_inv    = 1'b0;

        if (r_s1_special) begin
            w_result = r_s1_special_result;
            w_inv    = r_s1_invalid;
        end else begin
            if (r_s1_zero) begin
                w_result.sign = (r_s1_rm == RDN);
            end else if (r_s1_exp < 10'sd1) begin
                w_result.sign = r_s1_sign;
                w_unf         = 1'b1;
                w_inx         = 1'b1;
            end else if (w_exp_r >= 10'sd255) begin
                w_ovf = 1'b1;
                w_inx = 1'b1;
                if (overflow_to_maxfin(r_s1_rm, r_s1_sign)) begin
                    w_result = {r_s1_sign, FP_MAXFIN_MAG};
                end else begin
                    w_result = {r_s1_sign, 8'hFF, 23'h0};
                end
            end else begin
                w_result.sign = r_s1_sign;
                w_result.exp  = w_exp_r[7:0];
                w_result.frac = w_frac_sum[22:0];
                w_inx         = w_g | w_s;
            end
            // A flushed denormal operand already lost precision upstream.
            if (r_s1_flushed) begin
                w_inx = 1'b1;
            end
        end
    end

    fp_32b_t r_out;
    logic    r_ovf;
    logic    r_unf;
    logic    r_inx;
    logic    r_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_inx       <= 1'b0;
            r_inv       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_result;
                r_ovf <= w_ovf;
                r_unf <= w_unf;
                r_inx <= w_inx;
                r_inv <= w_inv;
            end
        end
    end

    assign bus.out_valid         = r_out_valid;
    assign bus.out               = r_out;
    assign bus.overflow          = r_ovf;
    assign bus.underflow         = r_unf;
    assign bus.inexact           = r_inx;
    assign bus.invalid_operation = r_inv;

`ifdef FP_NR_STICKY_FLAGS_EN
    logic [3:0] r_flags_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_sticky <= '0;
        end else if (flags_clear) begin
            r_flags_sticky <= '0;
        end else if (r_out_valid && bus.out_ready) begin
            r_flags_sticky <= r_flags_sticky | {r_inv, r_ovf, r_unf, r_inx};
        end
    end

    assign flags_sticky = r_flags_sticky;
`endif

endmodule
